// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of signals between the two pipeline requesters (IF fetch and MEM
// data), the shared single-ported RAM and mem_port_arbiter.
//
// Parameters:
//   ADDR_W - RAM address width
//   DATA_W - RAM data width
//
// Signal groups:
//   fetch side : if_req, if_addr, if_rdata, if_valid, stall_if
//   data side  : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_valid,
//                stall_mem
//   RAM side   : ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
//   status     : busy
//
// Modports:
//   slave  - the arbiter (takes requests, drives RAM controls and responses)
//   master - the environment (pipeline stages plus RAM)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_valid, mem_rdata, mem_valid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_valid, mem_rdata, mem_valid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified instruction/data RAM between the fetch
// stage (IF) and the memory stage (MEM). One access is granted at a time; the
// RAM controls are held stable for WAIT_CYCLES+1 cycles, then the owner gets a
// one-cycle valid pulse (the RESP cycle). Stall requests freeze the pipeline
// while an access is outstanding.
//
// Parameters:
//   ADDR_W      - RAM address width
//   DATA_W      - RAM data width
//   WAIT_CYCLES - extra RAM cycles per access (0..7)
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requests, responses, RAM, stalls, busy)
//
// Build option:
//   ARB_FAIR_EN - when defined, ties between eligible requesters go to the one
//                 not served last (round-robin). When undefined, data requests
//                 always win over fetch requests.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              owner_mem_reg;   // 1 = data access, 0 = fetch
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [2:0]        cnt_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] mem_rdata_reg;

`ifdef ARB_FAIR_EN
  logic              last_mem_reg;    // 1 = data was served last
`endif

  logic if_elig, mem_elig, grant, grant_mem;

  always_comb begin
    if_elig  = bus.if_req;
    mem_elig = bus.mem_req;
    // No grants while the RAM is busy; in RESP the requester just answered
    // still has its request up for this one cycle, so it must be masked.
    if (state_reg == S_ACCESS) begin
      if_elig  = 1'b0;
      mem_elig = 1'b0;
    end else if (state_reg == S_RESP) begin
      if (owner_mem_reg) mem_elig = 1'b0;
      else               if_elig  = 1'b0;
    end

`ifdef ARB_FAIR_EN
    grant_mem = mem_elig & (~if_elig | ~last_mem_reg);
`else
    grant_mem = mem_elig;
`endif
    grant = if_elig | mem_elig;

    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_RESP: state_next = grant ? S_ACCESS : S_IDLE;
      S_ACCESS:       if (cnt_reg == 3'd0) state_next = S_RESP;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      owner_mem_reg <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cnt_reg       <= 3'd0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
`ifdef ARB_FAIR_EN
      last_mem_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_mem_reg <= grant_mem;
        we_reg        <= grant_mem & bus.mem_we;
        addr_reg      <= grant_mem ? bus.mem_addr : bus.if_addr;
        wdata_reg     <= (grant_mem & bus.mem_we) ? bus.mem_wdata : '0;
        cnt_reg       <= 3'(WAIT_CYCLES);
`ifdef ARB_FAIR_EN
        last_mem_reg  <= grant_mem;
`endif
      end else if (state_reg == S_ACCESS) begin
        if (cnt_reg == 3'd0) begin
          // Last access cycle: RAM output is valid now.
          if (!we_reg) begin
            if (owner_mem_reg) mem_rdata_reg <= bus.ram_rdata;
            else               if_rdata_reg  <= bus.ram_rdata;
          end
        end else begin
          cnt_reg <= cnt_reg - 3'd1;
        end
      end
    end
  end

  assign bus.ram_en    = (state_reg == S_ACCESS);
  assign bus.ram_we    = bus.ram_en & we_reg;
  assign bus.ram_addr  = addr_reg;
  assign bus.ram_wdata = bus.ram_we ? wdata_reg : '0;

  assign bus.if_valid  = (state_reg == S_RESP) & ~owner_mem_reg;
  assign bus.mem_valid = (state_reg == S_RESP) &  owner_mem_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.mem_rdata = mem_rdata_reg;

  assign bus.stall_if  = bus.if_req  & ~bus.if_valid;
  assign bus.stall_mem = bus.mem_req & ~bus.mem_valid;
  assign bus.busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 2;
  localparam int P  = W + 2;   // cycles per access including RESP

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  // RAM behind the main DUT: unwritten words read as addr ^ 0x1224.
  logic [15:0] ram_mem [0:65535];
  bit          ram_wr  [0:65535];
  always @(posedge clk) begin
    if (bus_if.ram_we) begin
      ram_mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      ram_wr[bus_if.ram_addr]  <= 1'b1;
    end
  end
  assign bus_if.ram_rdata = ram_wr[bus_if.ram_addr] ? ram_mem[bus_if.ram_addr]
                                                    : (bus_if.ram_addr ^ 16'h1224);
  assign bus0.ram_rdata = bus0.ram_addr ^ 16'h0F0F;

  // Reference memory model and expected held read data.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] hold_i, hold_m;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h1224);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round starting from IDLE: optional fetch and optional
  // data access raised in the same cycle; every cycle is checked against the
  // expected timeline.
  task automatic do_round(input bit di, input logic [15:0] ia, input bit dm,
                          input bit we, input logic [15:0] ma, input logic [15:0] wd);
    int em, ei, last;
    logic [15:0] exp_m, exp_i, exp_addr;
    bit exp_en, exp_we;
    em = dm ? W + 2 : -1;
    ei = di ? (dm ? 2 * W + 4 : W + 2) : -1;
    last = ((em > ei) ? em : ei) + 1;
    exp_m = hold_m;
    if (dm) begin
      if (we) ref_mem[ma] = wd;
      else    exp_m = ref_rd(ma);
    end
    exp_i = di ? ref_rd(ia) : hold_i;
    for (int c = 0; c <= last; c++) begin
      step();
      if (c == 0) begin
        bus_if.if_req = di; bus_if.if_addr = ia;
        bus_if.mem_req = dm; bus_if.mem_we = we; bus_if.mem_addr = ma; bus_if.mem_wdata = wd;
      end
      if (dm && c == em + 1) bus_if.mem_req = 1'b0;
      if (di && c == ei + 1) bus_if.if_req = 1'b0;
      #1;
      exp_en = (c >= 1 && c <= W + 1) || (dm && di && c >= W + 3 && c <= 2 * W + 3);
      exp_addr = (dm && c <= W + 1) ? ma : ia;
      exp_we = exp_en && dm && we && c <= W + 1;
      n_checks++; if (bus_if.ram_en !== exp_en) begin n_fail++; $display("FAIL ram_en c=%0d got %b exp %b", c, bus_if.ram_en, exp_en); end
      if (exp_en) begin
        n_checks++; if (bus_if.ram_addr !== exp_addr) begin n_fail++; $display("FAIL ram_addr c=%0d got %h exp %h", c, bus_if.ram_addr, exp_addr); end
      end
      n_checks++; if (bus_if.ram_we !== exp_we) begin n_fail++; $display("FAIL ram_we c=%0d got %b exp %b", c, bus_if.ram_we, exp_we); end
      n_checks++; if (bus_if.ram_wdata !== (exp_we ? wd : 16'h0)) begin n_fail++; $display("FAIL ram_wdata c=%0d got %h exp %h", c, bus_if.ram_wdata, exp_we ? wd : 16'h0); end
      n_checks++; if (bus_if.mem_valid !== (c == em)) begin n_fail++; $display("FAIL mem_valid c=%0d got %b exp %b", c, bus_if.mem_valid, c == em); end
      n_checks++; if (bus_if.if_valid !== (c == ei)) begin n_fail++; $display("FAIL if_valid c=%0d got %b exp %b", c, bus_if.if_valid, c == ei); end
      n_checks++; if (bus_if.mem_rdata !== ((dm && c >= em) ? exp_m : hold_m)) begin n_fail++; $display("FAIL mem_rdata c=%0d got %h exp %h", c, bus_if.mem_rdata, (dm && c >= em) ? exp_m : hold_m); end
      n_checks++; if (bus_if.if_rdata !== ((di && c >= ei) ? exp_i : hold_i)) begin n_fail++; $display("FAIL if_rdata c=%0d got %h exp %h", c, bus_if.if_rdata, (di && c >= ei) ? exp_i : hold_i); end
      n_checks++; if (bus_if.stall_mem !== (dm && c < em)) begin n_fail++; $display("FAIL stall_mem c=%0d got %b exp %b", c, bus_if.stall_mem, dm && c < em); end
      n_checks++; if (bus_if.stall_if !== (di && c < ei)) begin n_fail++; $display("FAIL stall_if c=%0d got %b exp %b", c, bus_if.stall_if, di && c < ei); end
      n_checks++; if (bus_if.busy !== (c >= 1 && c < last)) begin n_fail++; $display("FAIL busy c=%0d got %b exp %b", c, bus_if.busy, c >= 1 && c < last); end
    end
    hold_m = exp_m;
    hold_i = exp_i;
    $display("txn: if=%0d addr=%h -> %h | mem=%0d we=%0d addr=%h wdata=%h -> %h",
             di, ia, exp_i, dm, we, ma, wd, exp_m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    #1;
    n_checks++; if ({bus_if.ram_en, bus_if.ram_we, bus_if.if_valid, bus_if.mem_valid, bus_if.busy} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {bus_if.ram_en, bus_if.ram_we, bus_if.if_valid, bus_if.mem_valid, bus_if.busy}); end
    n_checks++; if (bus_if.ram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_ram_addr got %h exp 0000", bus_if.ram_addr); end
    n_checks++; if (bus_if.ram_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_ram_wdata got %h exp 0000", bus_if.ram_wdata); end
    n_checks++; if ({bus_if.if_rdata, bus_if.mem_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {bus_if.if_rdata, bus_if.mem_rdata}); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got %b exp 0", bus0.busy); end
    step();
    rst_n = 1'b1;
    #1;
    hold_i = 16'h0;
    hold_m = 16'h0;
    $display("txn: reset");
  endtask

  task automatic test_single_fetch();
    do_round(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    n_checks++; if (bus_if.if_rdata !== 16'h1234) begin n_fail++; $display("FAIL single_fetch_data got %h exp 1234", bus_if.if_rdata); end
  endtask

  task automatic test_data_write();
    do_round(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
    do_round(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
    n_checks++; if (bus_if.mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL write_readback got %h exp beef", bus_if.mem_rdata); end
  endtask

  task automatic test_simultaneous();
    do_round(1'b1, 16'h0310, 1'b1, 1'b0, 16'h0300, 16'h0);
  endtask

  // Both requests held across several accesses: grants alternate
  // data, fetch, data, fetch with no idle gap between accesses.
  task automatic test_back_to_back();
    logic [15:0] ma, fa, em, ei;
    ma = 16'h0400; fa = 16'h0500;
    em = ref_rd(ma); ei = ref_rd(fa);
    for (int c = 0; c <= 4 * P + 1; c++) begin
      step();
      if (c == 0) begin
        bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = ma;
        bus_if.if_req = 1'b1; bus_if.if_addr = fa;
      end
      if (c == 3 * P + 1) bus_if.mem_req = 1'b0;
      if (c == 4 * P + 1) bus_if.if_req = 1'b0;
      #1;
      n_checks++; if (bus_if.mem_valid !== (c == P || c == 3 * P)) begin n_fail++; $display("FAIL b2b_mem_valid c=%0d got %b", c, bus_if.mem_valid); end
      n_checks++; if (bus_if.if_valid !== (c == 2 * P || c == 4 * P)) begin n_fail++; $display("FAIL b2b_if_valid c=%0d got %b", c, bus_if.if_valid); end
      n_checks++; if (bus_if.ram_en !== (c % P != 0 && c < 4 * P)) begin n_fail++; $display("FAIL b2b_ram_en c=%0d got %b exp %b", c, bus_if.ram_en, c % P != 0 && c < 4 * P); end
      n_checks++; if (bus_if.mem_rdata !== ((c >= P) ? em : hold_m)) begin n_fail++; $display("FAIL b2b_mem_rdata c=%0d got %h exp %h", c, bus_if.mem_rdata, (c >= P) ? em : hold_m); end
      n_checks++; if (bus_if.if_rdata !== ((c >= 2 * P) ? ei : hold_i)) begin n_fail++; $display("FAIL b2b_if_rdata c=%0d got %h exp %h", c, bus_if.if_rdata, (c >= 2 * P) ? ei : hold_i); end
      n_checks++; if (bus_if.busy !== (c >= 1 && c <= 4 * P)) begin n_fail++; $display("FAIL b2b_busy c=%0d got %b", c, bus_if.busy); end
      if (c > 0 && c % P == 0 && c <= 4 * P)
        $display("txn: b2b response %0d owner=%s", c / P, ((c / P) % 2 == 1) ? "data" : "fetch");
    end
    hold_m = em;
    hold_i = ei;
  endtask

  task automatic test_random();
    bit di, dm, we;
    logic [15:0] ia, ma, wd;
    for (int r = 0; r < 30; r++) begin
      dm = 1'($urandom_range(0, 1));
      di = dm ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = 16'h1000 + 16'($urandom_range(0, 15));
      ma = 16'h1000 + 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      do_round(di, ia, dm, we, ma, wd);
    end
  endtask

  task automatic test_reset_mid_access();
    step();
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 16'h0777; bus_if.mem_wdata = 16'h5555;
    #1;
    step(); #1;
    n_checks++; if (bus_if.ram_en !== 1'b1) begin n_fail++; $display("FAIL midrst_ram_en_c1 got %b exp 1", bus_if.ram_en); end
    step();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    bus_if.mem_req = 1'b0;
    #1;
    n_checks++; if (bus_if.ram_en !== 1'b0) begin n_fail++; $display("FAIL midrst_ram_en got %b exp 0", bus_if.ram_en); end
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus_if.busy); end
    n_checks++; if ({bus_if.if_rdata, bus_if.mem_rdata} !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h exp 0", {bus_if.if_rdata, bus_if.mem_rdata}); end
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus_if.mem_valid !== 1'b0 || bus_if.ram_en !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet c=%0d valid %b ram_en %b exp 0 0", c, bus_if.mem_valid, bus_if.ram_en); end
      step(); #1;
    end
    hold_i = 16'h0;
    hold_m = 16'h0;
    $display("txn: reset during write to 0777");
  endtask

  task automatic test_zero_wait();
    step();
    bus0.mem_req = 1'b1; bus0.mem_we = 1'b0; bus0.mem_addr = 16'h0042;
    #1;
    n_checks++; if (bus0.ram_en !== 1'b0 || bus0.stall_mem !== 1'b1) begin n_fail++; $display("FAIL zw_c0 ram_en %b stall %b exp 0 1", bus0.ram_en, bus0.stall_mem); end
    step(); #1;
    n_checks++; if (bus0.ram_en !== 1'b1 || bus0.ram_addr !== 16'h0042 || bus0.mem_valid !== 1'b0) begin n_fail++; $display("FAIL zw_c1 ram_en %b addr %h valid %b exp 1 0042 0", bus0.ram_en, bus0.ram_addr, bus0.mem_valid); end
    step(); #1;
    n_checks++; if (bus0.ram_en !== 1'b0 || bus0.mem_valid !== 1'b1) begin n_fail++; $display("FAIL zw_c2 ram_en %b valid %b exp 0 1", bus0.ram_en, bus0.mem_valid); end
    n_checks++; if (bus0.mem_rdata !== 16'h0F4D) begin n_fail++; $display("FAIL zw_rdata got %h exp 0f4d", bus0.mem_rdata); end
    step();
    bus0.mem_req = 1'b0;
    #1;
    n_checks++; if (bus0.mem_valid !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL zw_c3 valid %b busy %b exp 0 0", bus0.mem_valid, bus0.busy); end
    $display("txn: zero-wait read 0042 -> 0f4d");
  endtask

  initial begin
    bus_if.if_req = 1'b0; bus_if.if_addr = '0;
    bus_if.mem_req = 1'b0; bus_if.mem_we = 1'b0; bus_if.mem_addr = '0; bus_if.mem_wdata = '0;
    bus0.if_req = 1'b0; bus0.if_addr = '0;
    bus0.mem_req = 1'b0; bus0.mem_we = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
    hold_i = 16'h0;
    hold_m = 16'h0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported unified instruction/data RAM between two requesters: the fetch stage (IF) and the memory stage (MEM).
- Grants one access at a time and holds the RAM address, enable and write controls stable for a configurable number of wait states.
- Returns the read data with a one-cycle valid pulse.
- Drives stall requests so the pipeline freezes while an access is pending; these sit alongside the hazard detector's bubble, F/D-write and PC-write controls.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- WAIT_CYCLES, 2, extra RAM cycles per access (legal 0..7)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle fetch completion pulse
- mem_req  in  1  data request; held until mem_valid
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  load data
- mem_valid  out  1  one-cycle data completion pulse (reads and writes)
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid during the last access cycle
- stall_if  out  1  hold PC and F/D register
- stall_mem  out  1  freeze all pipeline registers
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - A pending request is granted: owner, we, addr and wdata are latched.
  - Wait counter loads WAIT_CYCLES; FSM moves to ACCESS.
- **Arbitration** (default): mem_req has fixed priority over if_req, because the MEM instruction is older.
- **ACCESS**
  - ram_en = 1; ram_addr, ram_we and ram_wdata come from the latched values and are stable for the whole state.
  - ram_we = 1 only for a granted data write; ram_wdata = 0 when not writing.
  - The counter decrements each cycle. When it reaches 0, ram_rdata is captured into the owner's rdata register (reads only) and the FSM moves to RESP.
- **RESP**
  - The owner's valid is pulsed; ram_en = 0.
  - The owner just answered is ineligible for grant this cycle. The other requester, if pending, is granted directly (RESP→ACCESS); otherwise the FSM goes to IDLE.
- if_rdata and mem_rdata hold their value until the next read by the same owner. Writes leave mem_rdata unchanged.
- Stalls are combinational:
  - stall_if = if_req & ~if_valid
  - stall_mem = mem_req & ~mem_valid
- The requester must drop or change its request in the cycle after valid. The arbiter does not check address stability during ACCESS; it uses only the latched values.

## Timing
- Reset values:
  - ram_en, ram_we, if_valid, mem_valid and busy = 0.
  - ram_addr, ram_wdata, if_rdata and mem_rdata = 0.
  - FSM = IDLE; fairness flag = 0.
- Reset mid-access: at the reset edge, ram_en drops and the FSM goes to IDLE. No valid pulse is issued and the in-flight write is abandoned.
- Latency:
  - Request seen in IDLE at cycle t.
  - ram_en is high for cycles t+1 .. t+1+WAIT_CYCLES.
  - valid is high at cycle t+2+WAIT_CYCLES.
  - A single access occupies WAIT_CYCLES+2 cycles.
- Back-to-back: a RESP→ACCESS handover has no idle gap. ram_en is low only in the RESP cycle.
- WAIT_CYCLES = 0: ACCESS lasts exactly one cycle.
- Both requests arriving in the same IDLE cycle: data first, then fetch via RESP handover.

## Configuration
- ARB_FAIR_EN
  - Defined: a fairness flag records the last owner. When both requests are eligible, the grant goes to the requester that was not last served (round-robin). The flag resets to 0, meaning data wins the first tie.
  - Undefined: fixed data-over-fetch priority; the flag is not built.

## Test plan
- Single fetch, WAIT_CYCLES=2: if_req=1, if_addr=0x0010, RAM word 0x1234 at cycle 0 → ram_en cycles 1–3 with ram_addr=0x0010; if_valid at cycle 4; if_rdata=0x1234; stall_if high cycles 0–3.
- Data write: mem_req=1, mem_we=1, addr 0x0200, wdata 0xBEEF → ram_we=1 for 3 cycles; mem_valid at cycle 4; a later read of 0x0200 returns 0xBEEF.
- Simultaneous requests: if_req=1 and mem_req=1 (read 0x0300) at cycle 0 → data served first, mem_valid at cycle 4. The RESP cycle hands over to fetch: ram_en for fetch in cycles 5–7, if_valid at cycle 8.
- Reset mid-access: mem_req write issued, rst_n=0 at cycle 2 → ram_en=0 from cycle 3, no mem_valid, busy=0, both rdata registers = 0.
- ARB_FAIR_EN defined, both requests held continuously → grant order data, fetch, data, fetch. Undefined → data is regranted on every IDLE tie, and fetch is granted only from RESP handovers.
- WAIT_CYCLES=0 read → ram_en for exactly one cycle; valid two cycles after the request.
